// File: rtl/pio_write_arbiter_if.sv
// Handshake bundle between the on-chip requesters, the arbiter and the
// PIO slave's Avalon-MM write port.
interface pio_write_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic [7:0]           current_value;
  logic [1:0]           av_address;
  logic                 av_chipselect;
  logic                 av_write_n;
  logic [31:0]          av_writedata;

  // Requester side: raises requests and watches for its ack / the bus.
  modport master (
    output req, req_data,
    input  ack, busy, current_value,
    input  av_address, av_chipselect, av_write_n, av_writedata
  );

  // Arbiter side: consumes requests and drives acks plus the PIO write port.
  modport slave (
    input  req, req_data,
    output ack, busy, current_value,
    output av_address, av_chipselect, av_write_n, av_writedata
  );
endinterface

// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter that funnels single-cycle writes from up to eight
// requesters into register 0 of an 8-bit output PIO, with a programmable
// hold-off after every write so the PIO output settles between updates.
module pio_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  pio_write_arbiter_if.slave bus_if
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [7:0]         cur_value_q, cur_value_d;
  logic [IDXW-1:0]    last_winner_q, last_winner_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               cs_q, cs_d;
  logic               write_n_q, write_n_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               found;
  logic [IDXW-1:0]    winner;
  logic [IDXW-1:0]    cand;
  int                 idx;
  logic [7:0]         win_data;

  // Round-robin search: scan upward from the slot after the last winner,
  // wrapping, so the last winner itself is considered last.
  always_comb begin
    found    = 1'b0;
    winner   = last_winner_q;
    cand     = last_winner_q;
    idx      = 0;
    win_data = 8'h00;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_winner_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDXW'(idx);
      if (!found && bus_if.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (IDXW'(j) == winner) win_data = bus_if.req_data[j*8 +: 8];
    end
  end

  // Next-state logic; the Avalon strobes and ack are computed one cycle
  // early so that they come straight out of flops during WRITE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_data_d     = wr_data_q;
    cur_value_d   = cur_value_q;
    last_winner_d = last_winner_q;
    ack_d         = '0;
    cs_d          = 1'b0;
    write_n_d     = 1'b1;
    wdata_d       = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = WRITE;
          wr_data_d     = win_data;
          last_winner_d = winner;
          ack_d         = NUM_REQ'(1) << winner;
          cs_d          = 1'b1;
          write_n_d     = 1'b0;
          wdata_d       = {24'h0, win_data};
        end
      end
      WRITE: begin
        cur_value_d = wr_data_q;
        if (HOLD_CYCLES > 0) begin
          state_d = HOLD;
          cnt_d   = 8'(HOLD_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset parks requester NUM_REQ-1 as the
  // last winner so requester 0 gets first pick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      wr_data_q     <= 8'h00;
      cur_value_q   <= 8'h00;
      last_winner_q <= IDXW'(NUM_REQ - 1);
      ack_q         <= '0;
      busy_q        <= 1'b0;
      cs_q          <= 1'b0;
      write_n_q     <= 1'b1;
      wdata_q       <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_data_q     <= wr_data_d;
      cur_value_q   <= cur_value_d;
      last_winner_q <= last_winner_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      cs_q          <= cs_d;
      write_n_q     <= write_n_d;
      wdata_q       <= wdata_d;
    end
  end

  assign bus_if.ack           = ack_q;
  assign bus_if.busy          = busy_q;
  assign bus_if.current_value = cur_value_q;
  assign bus_if.av_address    = 2'b00;
  assign bus_if.av_chipselect = cs_q;
  assign bus_if.av_write_n    = write_n_q;
  assign bus_if.av_writedata  = wdata_q;

endmodule

// File: doc/pio_write_arbiter.md
# pio_write_arbiter

Round-robin arbiter and write sequencer that shares the single 8-bit address output PIO slave between up to eight on-chip requesters, such as the Nios data master bridge and the correlation ASP control engines. It sits between the requesters and the PIO's Avalon-MM slave port. Each granted requester gets exactly one single-cycle Avalon write to PIO register 0. A programmable hold-off follows every write so that downstream logic sees a stable `out_port` value before the next update.

## Interface
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `HOLD_CYCLES`, 2, idle cycles enforced after each write; legal range 0..255.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `req`  in  NUM_REQ  per-requester write request, level.
- `req_data`  in  NUM_REQ*8  requester i's value is on bits [8i+7:8i].
- `ack`  out  NUM_REQ  one-hot, one-cycle pulse; the requester's write is being issued this cycle.
- `busy`  out  1  high in WRITE and HOLD.
- `current_value`  out  8  shadow of the last value written to the PIO.
- `av_address`  out  2  PIO slave address; always 0.
- `av_chipselect`  out  1  PIO chipselect.
- `av_write_n`  out  1  PIO write strobe, active-low.
- `av_writedata`  out  32  PIO write data, {24'b0, value}.

## Operation
- FSM states are IDLE, WRITE and HOLD.
- **IDLE:** if any `req` bit is high, choose a winner by round-robin, latch `req_data` of the winner into `wr_data`, latch the winner index into `last_winner`, and go to WRITE. If no request is pending, stay in IDLE.
- **Round-robin:** the search starts at index (`last_winner`+1) mod NUM_REQ and proceeds in ascending order with wrap. The first asserted `req` bit wins.
- **WRITE (exactly 1 cycle):**
  - Drive `av_chipselect`=1, `av_write_n`=0, `av_address`=0, `av_writedata`={24'b0, `wr_data`}.
  - Drive `ack[last_winner]`=1.
  - Update `current_value` <= `wr_data`.
  - Next state is HOLD if HOLD_CYCLES>0, otherwise IDLE.
- **HOLD:** load the counter with HOLD_CYCLES-1 on entry and decrement it each cycle. Return to IDLE after the cycle in which the counter reads 0, so HOLD lasts exactly HOLD_CYCLES cycles.
- Requests are not accepted in WRITE or HOLD; pending `req` bits simply wait.
- A requester holds `req` high and `req_data` stable until it sees `ack`.
  - Data is captured at the grant decision, so changes to `req_data` after the grant are ignored.
  - Dropping `req` after the grant does not cancel the write; it still completes and still produces `ack`.
  - Dropping `req` before the grant means no write occurs.
- A requester that keeps `req` high after its `ack` is treated as a new request and re-arbitrated.
- Outside WRITE: `av_chipselect`=0, `av_write_n`=1, `av_writedata`=0, `av_address`=0, `ack`=0.

## Timing
- **Reset values** (reset asserted, asynchronous):
  - state IDLE, counter 0, `wr_data`=0, `current_value`=0x00 (matches the PIO reset value);
  - `last_winner`=NUM_REQ-1, so requester 0 has top priority after reset;
  - `ack`=0, `busy`=0, `av_chipselect`=0, `av_write_n`=1, `av_writedata`=0.
- All outputs are registered; they change only on `clk` edges or on reset assertion.
- **Latency:** `req` seen high in IDLE at edge n means WRITE and `ack` are active during cycle n+1.
- **Write period** with continuous requests: HOLD_CYCLES+2 cycles (IDLE + WRITE + HOLD).
- `busy` rises in the WRITE cycle and falls on the cycle IDLE is re-entered.
- **Reset mid-operation:**
  - In WRITE, the write strobe deasserts immediately and the write may be lost. `current_value` returns to 0, consistent with the PIO also resetting.
  - In HOLD, the remaining hold-off is abandoned.
  - Nothing resumes after reset deasserts.
- **Boundary conditions:**
  - If the only requester is `last_winner`, it wins again after a full wrap.
  - With NUM_REQ=2, a shared pair of persistent requesters strictly alternates.
  - If all `req` bits are high, grants proceed in ascending order with wrap.
  - If `req` rises in the same cycle the FSM returns to IDLE, it is arbitrated at that edge with no extra bubble.

## Test plan
- **Reset:** assert `reset` mid-simulation without a clock edge -> all outputs at reset values immediately; `current_value`=0x00.
- **Single request:** `req`=0b0100, `req_data[23:16]`=0x5A, HOLD_CYCLES=2 -> after one clock, `ack`=0b0100, `av_writedata`=0x0000005A, `av_write_n`=0 for exactly 1 cycle; `current_value`=0x5A; `busy` high for 3 cycles.
- **All requesters at once:** all four `req` high with data 0x11/0x22/0x33/0x44 -> writes of 0x11, 0x22, 0x33, 0x44 in that order, strobes 4 cycles apart, each `ack` once.
- **Fairness:** `req[0]` and `req[3]` held high continuously -> grant order 0,3,0,3,...; no requester is granted twice in a row.
- **Withdrawal and data change after grant:** drop `req[1]` on the WRITE cycle and change `req_data` after the grant -> the latched value is still written and `ack[1]` still pulses. Separately, drop `req[2]` while in HOLD before its grant -> no write for requester 2.
- **Reset during HOLD, and HOLD_CYCLES=0:**
  - Reset during HOLD -> FSM is IDLE after release and the next grant goes to requester 0.
  - With HOLD_CYCLES=0 and `req[1]` held -> a write every 2 cycles.
